// File: rtl/router_vc_link.sv
// Multi-virtual-channel link endpoint: one flit FIFO per VC, muxed onto a single
// registered output with round-robin arbitration and wormhole (packet) locking.
module router_vc_link #(
    parameter int TYPE_WIDTH = 2,
    parameter int DATA_WIDTH = 32,
    parameter int VCHANNELS  = 2,
    parameter int DEPTH      = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [TYPE_WIDTH+DATA_WIDTH-1:0] lin_flit_i,
    input  logic [VCHANNELS-1:0]             lin_valid_i,
    output logic [VCHANNELS-1:0]             lin_ready_o,
    output logic [TYPE_WIDTH+DATA_WIDTH-1:0] lout_flit_o,
    output logic [VCHANNELS-1:0]             lout_valid_o,
    input  logic [VCHANNELS-1:0]             lout_ready_i,
    output logic                             err_o,
    output logic                             dbg_state_o
);

    localparam int FW = TYPE_WIDTH + DATA_WIDTH;
    localparam int VW = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [TYPE_WIDTH-1:0] TY_HEAD = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] TY_TAIL = TYPE_WIDTH'(3);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [VW-1:0]           lock_vc_q;
    logic [VW-1:0]           lock_vc_d;
    logic [VW-1:0]           rr_ptr_q;

    logic [FW-1:0]           mem    [VCHANNELS][DEPTH];
    logic [PW-1:0]           wr_ptr [VCHANNELS];
    logic [PW-1:0]           rd_ptr [VCHANNELS];
    logic [CW-1:0]           count  [VCHANNELS];

    logic [VCHANNELS-1:0]    not_empty;
    logic [VCHANNELS-1:0]    eligible;
    logic [VCHANNELS-1:0]    wr_sel;
    logic [VCHANNELS-1:0]    push;
    logic [VCHANNELS-1:0]    pop;
    logic                    multi_valid;
    logic                    out_free;
    logic                    grant_valid;
    logic [VW-1:0]           grant_vc;
    logic                    load;
    logic [FW-1:0]           head_flit;
    logic [TYPE_WIDTH-1:0]   head_type;
    logic                    head_err;

    // Handshake: a flit moves on a rising edge exactly when valid and ready are
    // both high for the same VC in the cycle before it. Input ready reflects
    // FIFO occupancy only; output valid/flit hold steady until accepted.
    always_comb begin
        for (int v = 0; v < VCHANNELS; v++) begin
            lin_ready_o[v] = ~reset & (count[v] != CW'(DEPTH));
            not_empty[v]   = (count[v] != '0);
        end
    end

    // Only the lowest requesting VC may write; more than one request is an error.
    assign wr_sel      = lin_valid_i & (~lin_valid_i + VCHANNELS'(1));
    assign multi_valid = (lin_valid_i & (lin_valid_i - VCHANNELS'(1))) != '0;
    assign push        = wr_sel & lin_ready_o;

    always_ff @(posedge clock) begin
        for (int v = 0; v < VCHANNELS; v++) begin
            if (push[v]) begin
                mem[v][wr_ptr[v]] <= lin_flit_i;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int v = 0; v < VCHANNELS; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
            end
        end else begin
            for (int v = 0; v < VCHANNELS; v++) begin
                if (push[v]) begin
                    wr_ptr[v] <= wr_ptr[v] + PW'(1);
                end
                if (pop[v]) begin
                    rd_ptr[v] <= rd_ptr[v] + PW'(1);
                end
                case ({push[v], pop[v]})
                    2'b10:   count[v] <= count[v] + CW'(1);
                    2'b01:   count[v] <= count[v] - CW'(1);
                    default: count[v] <= count[v];
                endcase
            end
        end
    end

    // A stalled flit on any VC blocks every VC (head-of-line by design).
    assign out_free  = (lout_valid_o == '0) | ((lout_valid_o & lout_ready_i) != '0);
    assign load      = out_free & grant_valid;
    assign head_flit = mem[grant_vc][rd_ptr[grant_vc]];
    assign head_type = head_flit[FW-1:DATA_WIDTH];
    assign head_err  = load & (state_q == ST_LOCKED) & (head_type == TY_HEAD);

    always_comb begin
        pop = '0;
        if (load) begin
            pop[grant_vc] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lout_valid_o <= '0;
            lout_flit_o  <= '0;
        end else if (load) begin
            lout_valid_o <= VCHANNELS'(1) << grant_vc;
            lout_flit_o  <= head_flit;
        end else if (out_free) begin
            lout_valid_o <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_o    <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            err_o <= multi_valid | head_err;
            if (load) begin
                rr_ptr_q <= grant_vc;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            lock_vc_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
        end
    end

    // FSM: next state. A head locks the output to its VC until the tail leaves.
    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        case (state_q)
            ST_IDLE: begin
                if (load && head_type == TY_HEAD) begin
                    state_d   = ST_LOCKED;
                    lock_vc_d = grant_vc;
                end
            end
            ST_LOCKED: begin
                if (load && head_type == TY_TAIL) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // FSM: outputs. Eligibility and the round-robin grant starting after rr_ptr_q.
    always_comb begin
        int idx;
        eligible    = '0;
        grant_valid = 1'b0;
        grant_vc    = '0;
        if (state_q == ST_LOCKED) begin
            eligible[lock_vc_q] = not_empty[lock_vc_q];
        end else begin
            eligible = not_empty;
        end
        for (int i = 1; i <= VCHANNELS; i++) begin
            idx = (int'(rr_ptr_q) + i) % VCHANNELS;
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_vc    = VW'(idx);
            end
        end
        dbg_state_o = (state_q == ST_LOCKED);
    end

endmodule

// File: tb/tb_router_vc_link.sv
// Bench for router_vc_link: directed scenarios with an ordered transfer
// scoreboard, then random traffic checked cycle by cycle against a queue model.
module tb_router_vc_link;

    localparam int TW    = 2;
    localparam int DW    = 32;
    localparam int NV    = 2;
    localparam int DEPTH = 4;
    localparam int FW    = TW + DW;
    localparam int EW    = NV + FW;

    logic          clock;
    logic          reset;
    logic [FW-1:0] lin_flit;
    logic [NV-1:0] lin_valid;
    logic [NV-1:0] lin_ready;
    logic [FW-1:0] lout_flit;
    logic [NV-1:0] lout_valid;
    logic [NV-1:0] lout_ready;
    logic          err;
    logic          dbg_state;

    int checks = 0;
    int errors = 0;
    bit sb_on  = 0;
    logic [EW-1:0] exp_q[$];

    // Reference model: per-VC queues plus the visible output stage.
    logic [FW-1:0] q0[$];
    logic [FW-1:0] q1[$];
    bit            m_valid;
    int            m_vc;
    logic [FW-1:0] m_flit;
    bit            m_err;
    bit            m_locked;
    int            m_lock_vc;
    int            m_ptr;

    router_vc_link #(
        .TYPE_WIDTH(TW), .DATA_WIDTH(DW), .VCHANNELS(NV), .DEPTH(DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .lin_flit_i  (lin_flit),
        .lin_valid_i (lin_valid),
        .lin_ready_o (lin_ready),
        .lout_flit_o (lout_flit),
        .lout_valid_o(lout_valid),
        .lout_ready_i(lout_ready),
        .err_o       (err),
        .dbg_state_o (dbg_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int qsize(input int v);
        return (v == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [FW-1:0] qpop(input int v);
        if (v == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void qpush(input int v, input logic [FW-1:0] f);
        if (v == 0) q0.push_back(f);
        else q1.push_back(f);
    endfunction

    function automatic logic [EW-1:0] mk(input int vc, input logic [1:0] ty, input logic [31:0] d);
        logic [NV-1:0] oh;
        oh     = '0;
        oh[vc] = 1'b1;
        return {oh, ty, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_edge();
        bit            free;
        bit            found;
        bit            h_err;
        int            g;
        int            w;
        logic [FW-1:0] f;
        logic [NV-1:0] pre_ready;
        if (reset) begin
            q0.delete();
            q1.delete();
            m_valid   = 0;
            m_vc      = 0;
            m_flit    = '0;
            m_err     = 0;
            m_locked  = 0;
            m_lock_vc = 0;
            m_ptr     = 0;
            return;
        end
        for (int v = 0; v < NV; v++) pre_ready[v] = qsize(v) < DEPTH;
        free  = !m_valid || lout_ready[m_vc];
        found = 0;
        g     = 0;
        for (int k = 1; k <= NV; k++) begin
            int c;
            c = (m_ptr + k) % NV;
            if (!found && qsize(c) > 0 && (!m_locked || c == m_lock_vc)) begin
                found = 1;
                g     = c;
            end
        end
        h_err = 0;
        if (free && found) begin
            f       = qpop(g);
            m_valid = 1;
            m_vc    = g;
            m_flit  = f;
            m_ptr   = g;
            if (m_locked) begin
                if (f[FW-1:DW] == 2'b11) m_locked = 0;
                else if (f[FW-1:DW] == 2'b01) h_err = 1;
            end else if (f[FW-1:DW] == 2'b01) begin
                m_locked  = 1;
                m_lock_vc = g;
            end
        end else if (free) begin
            m_valid = 0;
        end
        w = lin_valid[0] ? 0 : (lin_valid[1] ? 1 : -1);
        if (w >= 0 && pre_ready[w]) qpush(w, lin_flit);
        m_err = (lin_valid == 2'b11) || h_err;
    endtask

    task automatic check_model();
        logic [NV-1:0] ev;
        logic [NV-1:0] er;
        ev = m_valid ? (NV'(1) << m_vc) : '0;
        for (int v = 0; v < NV; v++) er[v] = !reset && (qsize(v) < DEPTH);
        check("m_lout_valid", lout_valid, ev);
        check("m_lout_flit", lout_flit, m_flit);
        check("m_err", err, m_err);
        check("m_lin_ready", lin_ready, er);
        check("m_state", dbg_state, m_locked);
    endtask

    task automatic tick();
        logic [EW-1:0] obs;
        logic [EW-1:0] expv;
        if (sb_on && (lout_valid & lout_ready) != '0) begin
            obs = {lout_valid, lout_flit};
            if (exp_q.size() > 0) expv = exp_q.pop_front();
            else expv = '1;
            check("sb_transfer", obs, expv);
        end
        @(posedge clock);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic send(input int vc, input logic [1:0] ty, input logic [31:0] d);
        lin_flit      = {ty, d};
        lin_valid     = '0;
        lin_valid[vc] = 1'b1;
        tick();
        lin_valid = '0;
    endtask

    initial begin
        reset      = 1'b1;
        lin_flit   = '0;
        lin_valid  = '0;
        lout_ready = '0;
        tick();
        tick();
        check("rst_valid", lout_valid, 2'b00);
        check("rst_flit", lout_flit, 34'h0);
        check("rst_ready_in_reset", lin_ready, 2'b00);
        reset = 1'b0;
        tick();
        check("t1_ready", lin_ready, 2'b11);
        sb_on = 1;

        // Single flit: visible one cycle after acceptance.
        lout_ready = 2'b11;
        send(0, 2'b00, 32'hDEADBEEF);
        check("t1_not_yet", lout_valid, 2'b00);
        exp_q.push_back(mk(0, 2'b00, 32'hDEADBEEF));
        tick();
        check("t1_valid", lout_valid, 2'b01);
        check("t1_flit", lout_flit, 34'h0DEADBEEF);
        tick();
        check("t1_idle", lout_valid, 2'b00);

        // Stall output on VC0, then fill VC1.
        lout_ready = 2'b00;
        send(0, 2'b00, 32'hAA);
        for (int i = 0; i < 4; i++) send(1, 2'b00, 32'h100 + i);
        check("t2_full", lin_ready, 2'b01);
        tick();
        tick();
        check("t2_hold_valid", lout_valid, 2'b01);
        check("t2_hold_flit", lout_flit, 34'hAA);
        exp_q.push_back(mk(0, 2'b00, 32'hAA));
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(1, 2'b00, 32'h100 + i));
        lout_ready = 2'b11;
        repeat (5) tick();
        check("t2_drained", exp_q.size(), 0);
        check("t2_idle", lout_valid, 2'b00);
        check("t2_ready", lin_ready, 2'b11);

        // Packet on VC0 must not interleave with VC1's single.
        lout_ready = 2'b00;
        send(0, 2'b01, 32'h1);
        send(1, 2'b00, 32'hA);
        send(0, 2'b10, 32'h2);
        send(0, 2'b11, 32'h3);
        check("t3_locked", dbg_state, 1'b1);
        exp_q.push_back(mk(0, 2'b01, 32'h1));
        exp_q.push_back(mk(0, 2'b10, 32'h2));
        exp_q.push_back(mk(0, 2'b11, 32'h3));
        exp_q.push_back(mk(1, 2'b00, 32'hA));
        lout_ready = 2'b11;
        repeat (4) tick();
        check("t3_drained", exp_q.size(), 0);
        check("t3_unlocked", dbg_state, 1'b0);

        // Round-robin alternation.
        lout_ready = 2'b00;
        for (int i = 0; i < 3; i++) begin
            send(0, 2'b00, 32'h40 + i);
            send(1, 2'b00, 32'h50 + i);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(0, 2'b00, 32'h40 + i));
            exp_q.push_back(mk(1, 2'b00, 32'h50 + i));
        end
        lout_ready = 2'b11;
        repeat (6) tick();
        check("t4_drained", exp_q.size(), 0);
        check("t4_idle", lout_valid, 2'b00);

        // Two valid bits: only VC0 written, err for one cycle.
        lin_flit  = {2'b00, 32'h55};
        lin_valid = 2'b11;
        tick();
        lin_valid = '0;
        check("t5_err_hi", err, 1'b1);
        exp_q.push_back(mk(0, 2'b00, 32'h55));
        tick();
        check("t5_err_lo", err, 1'b0);
        check("t5_valid", lout_valid, 2'b01);
        check("t5_flit", lout_flit, 34'h55);
        tick();
        tick();
        check("t5_no_vc1", lout_valid, 2'b00);

        // Reset mid-packet.
        lout_ready = 2'b00;
        send(0, 2'b01, 32'h1);
        send(0, 2'b10, 32'h2);
        send(1, 2'b00, 32'h3);
        send(0, 2'b10, 32'h4);
        check("t6_locked", dbg_state, 1'b1);
        reset = 1'b1;
        tick();
        check("t6_rst_valid", lout_valid, 2'b00);
        reset      = 1'b0;
        lout_ready = 2'b11;
        repeat (3) tick();
        check("t6_empty_valid", lout_valid, 2'b00);
        check("t6_ready", lin_ready, 2'b11);
        check("t6_idle", dbg_state, 1'b0);
        send(1, 2'b00, 32'h77);
        exp_q.push_back(mk(1, 2'b00, 32'h77));
        tick();
        check("t6_valid", lout_valid, 2'b10);
        check("t6_flit", lout_flit, 34'h77);
        tick();
        check("t6_drained", exp_q.size(), 0);
        sb_on = 0;

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int r;
            reset = ($urandom_range(0, 299) == 0);
            r     = $urandom_range(0, 15);
            if (r < 5) lin_valid = 2'b01;
            else if (r < 10) lin_valid = 2'b10;
            else if (r == 10) lin_valid = 2'b11;
            else lin_valid = 2'b00;
            lin_flit   = {2'($urandom_range(0, 3)), 32'($urandom)};
            lout_ready = 2'($urandom_range(0, 3));
            tick();
        end
        reset     = 1'b0;
        lin_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
